// File: rtl/part_2_pkg.sv
// part_2_pkg: shared states and default parameters for the delay detector
package part_2_pkg;
  typedef enum logic {SEARCH, LOCKED} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int SEL_W = $clog2(DEF_DEPTH);
endpackage

// File: rtl/part_2_delay_detector_if.sv
// part_2_delay_detector_if: sample bus into the detector and its measured result
// master drives clear/valid/d_ref/d_dly and reads sel/locked/ambiguous; slave is the detector
interface part_2_delay_detector_if import part_2_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic clear;
  logic valid;
  logic [WIDTH-1:0] d_ref;
  logic [WIDTH-1:0] d_dly;
  logic [$clog2(DEPTH)-1:0] sel;
  logic locked;
  logic ambiguous;
  modport master (output clear, valid, d_ref, d_dly, input sel, locked, ambiguous);
  modport slave (input clear, valid, d_ref, d_dly, output sel, locked, ambiguous);
endinterface

// File: rtl/part_2_tap_history.sv
// part_2_tap_history: d_ref history shift register and eligible-masked match vector
// in: clk, rst_n, clear_i, valid_i, d_ref_i, d_dly_i; out: match_o[k] = d_dly matches d_ref from k samples ago
module part_2_tap_history import part_2_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] d_ref_i,
  input  logic [WIDTH-1:0] d_dly_i,
  output logic [DEPTH-1:0] match_o
);
  localparam int SW = $clog2(DEPTH);
  logic [WIDTH-1:0] hist_q [1:DEPTH-1];
  logic [SW-1:0] fill_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '{default: '0};
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '{default: '0};
      fill_q <= '0;
    end else if (valid_i) begin
      hist_q[1] <= d_ref_i;
      for (int i = 2; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
      fill_q <= fill_q == SW'(DEPTH - 1) ? fill_q : fill_q + SW'(1);
    end
  end
  assign match_o[0] = valid_i && d_dly_i == d_ref_i;
  // tap k only holds real data once k samples have been seen since restart
  for (genvar k = 1; k < DEPTH; k++) begin : g_m
    assign match_o[k] = valid_i && fill_q >= SW'(k) && d_dly_i == hist_q[k];
  end
endmodule

// File: rtl/part_2_delay_detector.sv
// part_2_delay_detector: recovers the tap delay between d_ref and d_dly with lock hysteresis
// in: clk, rst_n, det.clear/valid/d_ref/d_dly; out: det.sel (delay), det.locked, det.ambiguous
module part_2_delay_detector import part_2_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input logic clk,
  input logic rst_n,
  part_2_delay_detector_if.slave det
);
  localparam int SW = $clog2(DEPTH);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);
  logic [DEPTH-1:0] m;
  state_t state_q, state_d;
  logic [SW-1:0] cand_q, cand_d, sel_q, sel_d, j;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] miss_q, miss_d;
  logic amb_q, amb_d, multi, one;
  part_2_tap_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_hist (
    .clk(clk), .rst_n(rst_n), .clear_i(det.clear), .valid_i(det.valid),
    .d_ref_i(det.d_ref), .d_dly_i(det.d_dly), .match_o(m)
  );
  // clearing the lowest set bit leaves something only when two or more bits are set
  assign multi = |(m & (m - DEPTH'(1)));
  assign one = |m && !multi;
  always_comb begin
    j = '0;
    for (int i = 0; i < DEPTH; i++) if (m[i]) j = SW'(i);
  end
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    miss_d = miss_q;
    sel_d = sel_q;
    amb_d = amb_q;
    if (det.valid && state_q == SEARCH) begin
      amb_d = multi;
      cand_d = one ? j : cand_q;
      cnt_d = !one ? '0 : j == cand_q ? cnt_q + CW'(1) : CW'(1);
      if (cnt_d == CW'(LOCK_CNT)) begin
        state_d = LOCKED;
        sel_d = cand_d;
        miss_d = '0;
      end
    end else if (det.valid) begin
      amb_d = 1'b0;
      miss_d = m[sel_q] ? '0 : miss_q + MW'(1);
      if (miss_d == MW'(UNLOCK_CNT)) begin
        state_d = SEARCH;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      cand_q <= '0;
      cnt_q <= '0;
      miss_q <= '0;
      sel_q <= '0;
      amb_q <= 1'b0;
    end else if (det.clear) begin
      state_q <= SEARCH;
      cand_q <= '0;
      cnt_q <= '0;
      miss_q <= '0;
      sel_q <= '0;
      amb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
      sel_q <= sel_d;
      amb_q <= amb_d;
    end
  end
  assign det.sel = sel_q;
  assign det.locked = state_q == LOCKED;
  assign det.ambiguous = amb_q;
endmodule

// File: tb/tb_part_2_delay_detector.sv
// tb_part_2_delay_detector: scoreboard bench against a queue-based reference model
module tb_part_2_delay_detector;
  import part_2_pkg::*;
  localparam int W = DEF_WIDTH;
  localparam int D = DEF_DEPTH;
  localparam int LC = DEF_LOCK_CNT;
  localparam int UC = DEF_UNLOCK_CNT;
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic locked;
    logic amb;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  part_2_delay_detector_if #(.WIDTH(W), .DEPTH(D)) bus ();
  part_2_delay_detector #(.WIDTH(W), .DEPTH(D), .LOCK_CNT(LC), .UNLOCK_CNT(UC)) dut (
    .clk(clk), .rst_n(rst_n), .det(bus)
  );
  int vectors = 0;
  int errors = 0;
  exp_t q[$];
  logic [W-1:0] mh[$];
  bit mlocked, mamb;
  int mcand, mcnt, mmiss, msel;
  logic [W-1:0] gh[$];
  logic [W-1:0] seq;
  function automatic exp_t dut_out();
    exp_t e;
    e.sel = bus.sel;
    e.locked = bus.locked;
    e.amb = bus.ambiguous;
    return e;
  endfunction
  function automatic exp_t model_out();
    exp_t e;
    e.sel = SEL_W'(msel);
    e.locked = mlocked;
    e.amb = mamb;
    return e;
  endfunction
  task automatic check(string name, exp_t act, exp_t exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got sel=%0d locked=%0b amb=%0b, want sel=%0d locked=%0b amb=%0b",
               name, $time, act.sel, act.locked, act.amb, exp.sel, exp.locked, exp.amb);
    end
  endtask
  task automatic model_reset();
    mh.delete();
    mlocked = 0;
    mamb = 0;
    mcand = 0;
    mcnt = 0;
    mmiss = 0;
    msel = 0;
  endtask
  // behavioural reference: mh[0] is the previous valid d_ref, mh[1] the one before, ...
  task automatic model_step(bit clr, bit v, logic [W-1:0] dr, logic [W-1:0] dd);
    int nm, j;
    bit hit, e;
    logic [W-1:0] h;
    if (clr) begin
      model_reset();
      return;
    end
    if (!v) return;
    nm = 0;
    j = 0;
    hit = 0;
    for (int k = 0; k < D; k++) begin
      e = k == 0 || k <= mh.size();
      h = k == 0 ? dr : (e ? mh[k-1] : '0);
      if (e && dd == h) begin
        nm++;
        j = k;
        if (k == msel) hit = 1;
      end
    end
    if (!mlocked) begin
      mamb = nm > 1;
      if (nm == 1) begin
        mcnt = j == mcand ? mcnt + 1 : 1;
        mcand = j;
      end else mcnt = 0;
      if (mcnt == LC) begin
        mlocked = 1;
        msel = mcand;
        mmiss = 0;
      end
    end else begin
      mamb = 0;
      mmiss = hit ? 0 : mmiss + 1;
      if (mmiss == UC) begin
        mlocked = 0;
        mcnt = 0;
      end
    end
    mh.push_front(dr);
    if (mh.size() > D - 1) void'(mh.pop_back());
  endtask
  task automatic sample(bit v, logic [W-1:0] dr, logic [W-1:0] dd, bit clr);
    @(negedge clk);
    bus.valid = v;
    bus.d_ref = dr;
    bus.d_dly = dd;
    bus.clear = clr;
    model_step(clr, v, dr, dd);
    q.push_back(model_out());
  endtask
  task automatic idle();
    sample(0, W'($urandom), W'($urandom), 0);
  endtask
  task automatic stream(int n, int dly, bit gaps);
    logic [W-1:0] dd;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) idle();
      dd = dly == 0 ? seq : (gh.size() >= dly ? gh[dly-1] : '0);
      sample(1, seq, dd, 0);
      gh.push_front(seq);
      if (gh.size() > 8) void'(gh.pop_back());
      seq++;
    end
  endtask
  // monitor: outputs are registered, so each queued expectation is due just after the next edge
  initial forever begin
    @(posedge clk);
    #2;
    if (q.size() > 0) check("scoreboard", dut_out(), q.pop_front());
  end
  initial begin
    exp_t z;
    int dly;
    logic [W-1:0] dr, dd;
    int r;
    z = '0;
    bus.valid = 0;
    bus.clear = 0;
    bus.d_ref = '0;
    bus.d_dly = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #2;
    check("reset", dut_out(), z);
    idle();
    idle();
    seq = 8'h01;
    gh.delete();
    stream(8, 2, 0);
    stream(8, 3, 0);
    idle();
    @(posedge clk);
    #4;
    rst_n = 0;
    #1;
    check("async_reset", dut_out(), z);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    stream(8, 3, 0);
    sample(1, W'($urandom), W'($urandom), 1);
    stream(9, 3, 0);
    sample(0, '0, '0, 1);
    for (int i = 0; i < 20; i++) sample(1, 8'h55, 8'h55, 0);
    sample(0, '0, '0, 1);
    seq = 8'h01;
    gh.delete();
    stream(8, 2, 1);
    dly = $urandom_range(0, D - 1);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) sample(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1);
      else if (r < 25) idle();
      else begin
        if ($urandom_range(0, 39) == 0) dly = $urandom_range(0, D - 1);
        dr = i < 250 ? W'($urandom) : W'($urandom_range(0, 7));
        dd = $urandom_range(0, 9) == 0 ? W'($urandom) :
             dly == 0 ? dr : (gh.size() >= dly ? gh[dly-1] : W'($urandom));
        sample(1, dr, dd, 0);
        gh.push_front(dr);
        if (gh.size() > 8) void'(gh.pop_back());
      end
    end
    idle();
    repeat (4) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/part_2_delay_detector.md
# part_2_delay_detector

Measures the sample delay between a reference byte stream and a delayed copy of it, reporting which tap index (0..DEPTH-1) the delayed stream corresponds to. It is the receiving end of the lab's tapped-delay/tap-select path: it consumes the original input and the tap-selected output and recovers the select value in use. It tracks lock with hysteresis and flags data too uniform to resolve.

## Interface
- WIDTH, 8, data width
- DEPTH, 4, number of candidate delays (0..DEPTH-1), power of two ≥ 2
- LOCK_CNT, 4, consecutive unique matches on one candidate needed to lock
- UNLOCK_CNT, 2, consecutive mismatches on locked tap needed to drop lock

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous restart, same effect as reset except it is sampled on clk
- valid  in  1  d_ref/d_dly pair is a sample this cycle
- d_ref  in  WIDTH  undelayed stream
- d_dly  in  WIDTH  delayed stream under test
- sel  out  $clog2(DEPTH)  measured delay, registered
- locked  out  1  sel is valid, registered
- ambiguous  out  1  last SEARCH sample matched more than one candidate, registered

## Operation
- History: hist_0 = current d_ref (combinational); hist_k (k ≥ 1) = d_ref from k valid samples ago, held in a DEPTH-1 deep shift register advanced only on valid.
- Eligibility: fill counter counts valid samples since reset/clear, saturating at DEPTH-1. Candidate k is eligible when fill ≥ k.
- Match vector: m[k] = eligible(k) && (d_dly == hist_k), evaluated only when valid=1.
- valid=0: history, fill, counters, state and outputs all hold; d_ref/d_dly ignored.
- States: SEARCH (reset state) and LOCKED.
- SEARCH, per valid sample:
  - exactly one bit set at index j: if j == cand, cnt++; else cand=j, cnt=1. ambiguous=0.
  - zero bits set: cnt=0, ambiguous=0.
  - two or more bits set: cnt=0, ambiguous=1.
  - when the updated cnt equals LOCK_CNT: go to LOCKED, sel=cand, locked=1, miss=0.
- LOCKED, per valid sample:
  - m[sel]=1 (other bits ignored): miss=0.
  - m[sel]=0: miss++. When miss reaches UNLOCK_CNT: go to SEARCH, locked=0, cnt=0, cand unchanged. sel holds its last value.
  - ambiguous forced 0.
- clear=1 on a posedge: same state as reset, regardless of valid. This takes priority over all other updates.
- Counter widths: cnt holds 0..LOCK_CNT and miss holds 0..UNLOCK_CNT. Neither wraps.

## Timing
- Reset (async assert) sets sel=0, locked=0, ambiguous=0, state=SEARCH, history=0, fill=0, cnt=0, miss=0, cand=0. Takes effect immediately, mid-operation included.
- Outputs are registered and change only on posedge after a valid sample, or on clear/reset.
- Lock latency: locked rises on the edge that samples the LOCK_CNT-th consecutive unique match. With a fresh history and delay k, this is valid sample index k+LOCK_CNT-1 (0-based).
- Unlock latency: locked falls on the edge sampling the UNLOCK_CNT-th consecutive miss. The first SEARCH counting sample is the next valid sample.
- No output depends combinationally on inputs.

## Structure
- Shared package part_2_pkg:
  - state enum {SEARCH, LOCKED}
  - SEL_W = $clog2(DEPTH)
  - default parameter constants
- One sub-module, part_2_tap_history. It holds the shift register plus fill counter, and outputs the eligible-masked match vector given d_ref, d_dly and valid. The FSM and counters stay in the top.

## Test plan
- Reset values: hold rst_n=0, then release with no valid. Required: sel=0, locked=0, ambiguous=0; asserting rst_n low asynchronously mid-cycle clears all three before the next edge.
- Lock on delay 2: d_ref=0x01,0x02,0x03…, d_dly=0x00,0x00,0x01,0x02… (every cycle valid). Required: locked=1 and sel=2 after the edge of sample 5; ambiguous stays 0.
- Uniform data: d_ref=d_dly=0x55 for 20 samples. Required: ambiguous=1 from sample 1 onward and locked never asserts.
- Relock: after locking at delay 2, switch d_dly to delay 3 of the incrementing stream. Required: locked drops after the 2nd post-switch sample, then locked=1 and sel=3 after the 6th post-switch sample.
- Valid gaps: repeat the delay-2 case with valid toggling 1,0,1,0… and garbage d_ref/d_dly on invalid cycles. Required: lock occurs at the 6th valid sample with sel=2, identical to the gap-free case.
- Clear: while locked, assert clear for one cycle with valid=1. Required: sel=0 and locked=0 after that edge. Relock then takes k+LOCK_CNT samples again, showing the fill counter restarted.
